// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   - word width and opcode field position within an instruction word
//   - major opcode constants seen by the control decoder
//   - fetch stage FSM state encoding
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/mips_pc_next.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   pc          in   current PC
//   instr       in   instruction being executed (branch offset / jump index)
//   take_branch in   resolved branch taken
//   jump        in   jump selected; overrides take_branch
//   pc_plus4    out  pc + 4
//   next_pc     out  selected successor PC
module mips_pc_next
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] instr,
    input  logic              take_branch,
    input  logic              jump,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] br_off;
    logic [WORD_W-1:0] br_tgt;
    logic [WORD_W-1:0] j_tgt;
    logic              unused_opc;

    // Opcode bits are decoded upstream into jump/take_branch.
    assign unused_opc = &{1'b0, instr[OPC_HI:OPC_LO]};

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_tgt   = pc_plus4 + br_off;
    assign j_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = j_tgt;
        else if (take_branch)
            next_pc = br_tgt;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word over a req/ack
// handshake, holds it in the instruction register while the datapath
// executes, then advances the PC on exec_done.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_req/addr   fetch request and word address (addr == pc)
//   imem_ack/rdata  fetch data valid / fetched word
//   instr, opcode   instruction register and its opcode field
//   instr_valid     instr is stable for execution
//   exec_done       datapath finished the current instruction
//   take_branch     resolved branch taken
//   jump            jump selected (wins over take_branch)
//   pc, pc_plus4    current PC and pc + 4
//   fetch_err       sticky fetch timeout flag, cleared only by reset
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0040_0000,
    parameter int                MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [OPC_W-1:0]  opcode,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              take_branch,
    input  logic              jump,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              fetch_err
);

    // Keep a 1-bit counter when the timeout is disabled so widths stay legal.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    fetch_state_e      state, state_nxt;
    logic [CW-1:0]     wait_cnt;
    logic [WORD_W-1:0] next_pc;
    logic              timeout;
    logic              req_nxt, vld_nxt, err_nxt;

    mips_pc_next u_pc_next (
        .pc          (pc),
        .instr       (instr),
        .take_branch (take_branch),
        .jump        (jump),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc)
    );

    // Fires during the last allowed FETCH cycle: the counter would reach
    // MAX_WAIT on this edge, giving exactly MAX_WAIT cycles of waiting.
    generate
        if (MAX_WAIT == 0) begin : g_no_to
            assign timeout = 1'b0;
        end else begin : g_to
            assign timeout = (wait_cnt == CW'(MAX_WAIT - 1));
        end
    endgenerate

    // State register; Moore outputs are registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            imem_req    <= req_nxt;
            instr_valid <= vld_nxt;
            fetch_err   <= err_nxt;
        end
    end

    // Next state. Ack is checked before timeout so a coincident ack wins.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)
                    state_nxt = ST_ISSUE;
                else if (timeout)
                    state_nxt = ST_ERR;
            end
            ST_ISSUE: if (exec_done) state_nxt = ST_FETCH;
            ST_ERR:   state_nxt = ST_ERR;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        req_nxt = (state_nxt == ST_FETCH);
        vld_nxt = (state_nxt == ST_ISSUE);
        err_nxt = (state_nxt == ST_ERR);
    end

    // PC, instruction register and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr    <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == ST_FETCH && imem_ack)
                instr <= imem_rdata;
            if (state == ST_ISSUE && exec_done)
                pc <= next_pc;
            if (state != ST_FETCH && state_nxt == ST_FETCH)
                wait_cnt <= '0;
            else if (state == ST_FETCH && !imem_ack)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign opcode    = instr[OPC_HI:OPC_LO];
    assign imem_addr = {pc[WORD_W-1:2], 2'b00};

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        take_branch;
    logic        jump;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural PC and the word the stage should hold.
    logic [31:0] mpc;
    logic [31:0] minstr;

    mips_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .take_branch (take_branch),
        .jump        (jump),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Successor PC from the ISA rules, computed arithmetically.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input bit tb, input bit j);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (j)  return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (tb) return seq + 32'(int'($signed(ins[15:0])) * 4);
        return seq;
    endfunction

    // Reset, release, and land on the first FETCH cycle.
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; take_branch = 1'b0; jump = 1'b0;
        step(); step();
        rst = 1'b0;
        mpc = RST_PC; minstr = '0;
        step();
    endtask

    // Wait lat cycles without ack (with noise on ignored inputs), then ack word.
    task automatic do_fetch(input logic [31:0] word, input int lat);
        for (int i = 0; i < lat; i++) begin
            check("req_wait", imem_req, 1'b1);
            check("addr_wait", imem_addr, mpc);
            imem_ack = 1'b0; imem_rdata = $urandom;
            exec_done = 1'($urandom); jump = 1'($urandom); take_branch = 1'($urandom);
            step();
        end
        check("req_ack", imem_req, 1'b1);
        check("addr_ack", imem_addr, mpc);
        imem_ack = 1'b1; imem_rdata = word;
        step();
        imem_ack = 1'b0; exec_done = 1'b0; jump = 1'b0; take_branch = 1'b0;
        minstr = word;
        check("valid_issue", instr_valid, 1'b1);
        check("req_issue", imem_req, 1'b0);
        check("instr", instr, minstr);
        check("opcode", {26'b0, opcode}, {26'b0, minstr[31:26]});
    endtask

    // Hold ISSUE for dly cycles, then complete with the given controls.
    task automatic do_exec(input bit j, input bit tb, input int dly);
        for (int i = 0; i < dly; i++) begin
            check("valid_hold", instr_valid, 1'b1);
            check("instr_hold", instr, minstr);
            check("pc_plus4", pc_plus4, mpc + 32'd4);
            exec_done = 1'b0;
            imem_ack = 1'($urandom); jump = 1'($urandom); take_branch = 1'($urandom);
            step();
        end
        imem_ack = 1'b0; exec_done = 1'b1; jump = j; take_branch = tb;
        step();
        exec_done = 1'b0; jump = 1'b0; take_branch = 1'b0;
        mpc = model_next(mpc, minstr, tb, j);
        check("valid_done", instr_valid, 1'b0);
        check("req_done", imem_req, 1'b1);
        check("addr_done", imem_addr, mpc);
        check("pc_done", pc, mpc);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; take_branch = 1'b0; jump = 1'b0;
        step();
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", {26'b0, opcode}, 32'h0);

        // First fetch, immediate ack, then sequential flow.
        rst = 1'b0; mpc = RST_PC; minstr = '0;
        check("idle_req", imem_req, 1'b0);
        step();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0040_0000);
        do_fetch(32'h2008_0005, 0);
        check("addi_opcode", {26'b0, opcode}, 32'h08);
        do_exec(1'b0, 1'b0, 0);
        check("seq_addr", imem_addr, 32'h0040_0004);

        // Backward branch from 0x00400008.
        do_fetch(32'h0000_0000, 1);
        do_exec(1'b0, 1'b0, 1);
        check("br_pc_pre", pc, 32'h0040_0008);
        do_fetch(32'h1000_FFFE, 0);
        do_exec(1'b0, 1'b1, 1);
        check("br_pc", pc, 32'h0040_0004);

        // Jump beats branch.
        do_reset();
        do_fetch(32'h0810_0010, 0);
        do_exec(1'b1, 1'b1, 0);
        check("jmp_pc", pc, 32'h0040_0040);

        // Timeout after 4 FETCH cycles; ERR is sticky and ignores inputs.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check("to_req", imem_req, 1'b1);
            check("to_err_lo", fetch_err, 1'b0);
            step();
        end
        check("to_err", fetch_err, 1'b1);
        check("to_req_off", imem_req, 1'b0);
        imem_ack = 1'b1; exec_done = 1'b1;
        step(); step();
        imem_ack = 1'b0; exec_done = 1'b0;
        check("err_sticky", fetch_err, 1'b1);
        check("err_novalid", instr_valid, 1'b0);

        // Ack on the 4th cycle wins over the timeout.
        do_reset();
        do_fetch(32'h8C08_0004, 3);
        check("late_ack_err", fetch_err, 1'b0);

        // Asynchronous reset mid-fetch.
        do_reset();
        check("mid_req", imem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("async_req", imem_req, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("async_valid", instr_valid, 1'b0);
        check("async_instr", instr, 32'h0);
        rst = 1'b0; mpc = RST_PC; minstr = '0;
        step();
        imem_ack = 1'b0;
        check("restart_valid", instr_valid, 1'b0);
        check("restart_addr", imem_addr, RST_PC);
        do_fetch(32'hAC09_0008, 1);

        // Randomized instruction stream against the reference model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            do_fetch($urandom, $urandom_range(0, 3));
            do_exec(1'($urandom), 1'($urandom), $urandom_range(0, 2));
            check("rnd_err", fetch_err, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage of the MIPS core, directly upstream of the control decoder. Holds the PC, fetches one 32-bit word at a time from instruction memory over a req/ack handshake, latches it into the instruction register, and presents `instr`/`opcode` to the decoder and datapath. When the datapath signals completion, the stage computes the next PC from the resolved branch and jump controls and starts the next fetch.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value after reset; must be word aligned.
- MAX_WAIT, 16, fetch timeout in cycles; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until acked.
- imem_addr  out  32  fetch address, equal to `pc`.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched word, sampled when `imem_ack` is high.
- instr  out  32  instruction register.
- opcode  out  6  `instr[31:26]`, drives the decoder.
- instr_valid  out  1  `instr` is held stable for execution.
- exec_done  in  1  datapath has finished the current instruction.
- take_branch  in  1  resolved branch taken, i.e. the branch control ANDed with the condition.
- jump  in  1  jump selected (decoder branch/jump select = 0).
- pc  out  32  current PC.
- pc_plus4  out  32  `pc + 4`, combinational.
- fetch_err  out  1  sticky timeout flag.

## Operation
- FSM states:
  - IDLE: entered on reset.
  - FETCH: `imem_req` = 1.
  - ISSUE: `instr_valid` = 1.
  - ERR: `fetch_err` = 1, `imem_req` = 0.
- Transitions:
  - IDLE -> FETCH on the first clock with `rst` low.
  - FETCH -> ISSUE when `imem_ack` is sampled high; `instr` <= `imem_rdata` on the same edge.
  - FETCH -> ERR when the wait counter reaches MAX_WAIT without an ack (only if MAX_WAIT != 0).
  - ISSUE -> FETCH on `exec_done`; `pc` <= next PC on the same edge.
  - ERR is exited only by reset.
- Next PC, with jump taking priority:
  - `jump`: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else `take_branch`: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}) mod 2^32.
  - else: pc_plus4.
- `imem_addr[1:0]` is always 2'b00.
- Wait counter:
  - Width $clog2(MAX_WAIT+1).
  - Cleared on entry to FETCH; increments each FETCH cycle without an ack.
- Ignored inputs:
  - `imem_ack` outside FETCH.
  - `exec_done`, `take_branch` and `jump` outside ISSUE.
- PC wrap-around at 2^32 is silent.

## Timing
- Reset values: `pc` = RESET_PC, `instr` = 0 (opcode 0, an R-type nop), `imem_req` = 0, `instr_valid` = 0, `fetch_err` = 0, state IDLE.
- All outputs except `opcode`, `imem_addr` and `pc_plus4` are registered (Moore).
- `imem_req` rises one cycle after `rst` deasserts.
- An ack in the first FETCH cycle gives `instr_valid` = 1 on the next cycle.
- `exec_done` in cycle N gives `instr_valid` = 0 and `imem_req` = 1 with the new address in cycle N+1.
- Minimum throughput: 2 cycles per instruction.
- `imem_addr` is stable for the whole time `imem_req` is high.
- `instr` is stable for the whole time `instr_valid` is high.
- Ack on the same edge as the timeout: the ack wins and the FSM goes to ISSUE.
- `take_branch` and `jump` both high: the jump target is used.
- `rst` asserted mid-fetch or mid-issue: all state clears immediately (asynchronously); any outstanding ack is ignored.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (R-type, ADDI, LW, SW, BEQ, BNE, J);
  - the FSM state enum;
  - the word width (32) and the opcode field slice positions.
- One sub-module: `mips_pc_next`, purely combinational. Inputs `pc`, `instr`, `take_branch`, `jump`; outputs `pc_plus4` and `next_pc`.
- Counter, FSM, PC register and instruction register live in `mips_fetch_unit`.

## Test plan
- Reset release, memory acks immediately with 32'h2008_0005 -> `imem_addr` = 32'h0040_0000; one cycle later `instr_valid` = 1 and `opcode` = 6'b001000.
- Sequential flow: `exec_done` with no branch/jump at pc 32'h0040_0000 -> next `imem_addr` = 32'h0040_0004, with `imem_req` high one cycle after `exec_done`.
- Backward branch: pc = 32'h0040_0008, instr = BEQ with offset 16'hFFFE, `take_branch` = 1, `exec_done` -> `pc` = 32'h0040_0004.
- Jump priority: pc = 32'h0040_0000, instr = 32'h0810_0010, `jump` = 1 and `take_branch` = 1 -> `pc` = 32'h0040_0040.
- Timeout with MAX_WAIT = 4: no ack -> `fetch_err` = 1 and `imem_req` = 0 after 4 FETCH cycles; repeat with an ack on the 4th cycle -> no error, FSM goes to ISSUE.
- Reset mid-fetch: assert `rst` while `imem_req` = 1 -> `imem_req` falls without a clock edge; after release, fetch restarts at RESET_PC.
